// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory-side types: data word, RAM handshake state, arbiter FSM state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto a single-port RAM, dcache-first with a starvation guard
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int unsigned         STREAK_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;
    logic                d_req;
    logic                access;

    assign d_req  = dREN | dWEN;
    assign access = (ramstate == ACCESS);

    // Read data is shared; each side qualifies it with its own wait.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    always_comb begin
        state_next  = state;
        streak_next = streak;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = iREN;
        dwait       = d_req;

        case (state)
            IDLE: begin
                // dcache wins unless the icache has already yielded STARVE_LIMIT times
                if (d_req) begin
                    if (iREN && (streak == STREAK_MAX)) begin
                        state_next = IGRANT;
                    end else begin
                        state_next = DGRANT;
                    end
                end else if (iREN) begin
                    state_next = IGRANT;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~access;
                if (!iREN) begin
                    state_next = IDLE;
                end else if (access) begin
                    state_next  = IDLE;
                    streak_next = '0;
                end
            end

            DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~access;
                if (!d_req) begin
                    state_next = IDLE;
                end else if (access) begin
                    state_next = IDLE;
                    if (!iREN) begin
                        streak_next = '0;
                    end else if (streak != STREAK_MAX) begin
                        streak_next = streak + STREAK_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter: directed table, corner sequences, random vs model
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic       ir, dr, dw;
        word_t      ia, da, ds;
        ramstate_t  rs;
        word_t      ld;
        arb_state_t st;
        logic       ren, wen, iw, dwt;
        word_t      addr, store;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                                input word_t ia, input word_t da, input word_t ds,
                                input ramstate_t rs, input word_t ld, input arb_state_t st,
                                input logic ren, input logic wen, input logic iw, input logic dwt,
                                input word_t addr, input word_t store);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
        v.rs = rs; v.ld = ld; v.st = st; v.ren = ren; v.wen = wen;
        v.iw = iw; v.dwt = dwt; v.addr = addr; v.store = store;
        return v;
    endfunction

    task automatic drive(input logic ir, input logic dr, input logic dw, input word_t ia,
                         input word_t da, input word_t ds, input ramstate_t rs, input word_t ld);
        iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
        ramstate = rs; ramload = ld;
    endtask

    vec_t tbl[$];

    // model state
    int   m_owner;
    int   m_streak;
    logic e_ren, e_wen, e_iw, e_dw, dq, acc;
    word_t e_addr, e_store;
    int   nd;
    logic igot;

    initial begin
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // single fetch
        tbl.push_back(mk(0,0,0, 0,0,0, FREE,0, IDLE, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0, 'h100,0,0, FREE,0, IDLE, 0,0,1,0, 0,0));
        tbl.push_back(mk(1,0,0, 'h100,0,0, BUSY,0, IGRANT, 1,0,1,0, 'h100,0));
        tbl.push_back(mk(1,0,0, 'h100,0,0, BUSY,0, IGRANT, 1,0,1,0, 'h100,0));
        tbl.push_back(mk(1,0,0, 'h100,0,0, ACCESS,'hDEADBEEF, IGRANT, 1,0,0,0, 'h100,0));
        tbl.push_back(mk(0,0,0, 0,0,0, FREE,0, IDLE, 0,0,0,0, 0,0));
        // contention: dcache first, icache after the dead cycle
        tbl.push_back(mk(1,0,1, 'h104,'h200,'h55, FREE,0, IDLE, 0,0,1,1, 0,0));
        tbl.push_back(mk(1,0,1, 'h104,'h200,'h55, BUSY,0, DGRANT, 0,1,1,1, 'h200,'h55));
        tbl.push_back(mk(1,0,1, 'h104,'h200,'h55, ACCESS,0, DGRANT, 0,1,1,0, 'h200,'h55));
        tbl.push_back(mk(1,0,0, 'h104,0,0, FREE,0, IDLE, 0,0,1,0, 0,0));
        tbl.push_back(mk(1,0,0, 'h104,0,0, ACCESS,'hCAFE0001, IGRANT, 1,0,0,0, 'h104,0));
        tbl.push_back(mk(0,0,0, 0,0,0, FREE,0, IDLE, 0,0,0,0, 0,0));
        // error retry on a dcache read
        tbl.push_back(mk(0,1,0, 0,'h300,0, FREE,0, IDLE, 0,0,0,1, 0,0));
        tbl.push_back(mk(0,1,0, 0,'h300,0, ERROR,0, DGRANT, 1,0,0,1, 'h300,0));
        tbl.push_back(mk(0,1,0, 0,'h300,0, ERROR,0, DGRANT, 1,0,0,1, 'h300,0));
        tbl.push_back(mk(0,1,0, 0,'h300,0, ACCESS,'h12345678, DGRANT, 1,0,0,0, 'h300,0));
        tbl.push_back(mk(0,0,0, 0,0,0, FREE,0, IDLE, 0,0,0,0, 0,0));
        // write beats read
        tbl.push_back(mk(0,1,1, 0,'h310,'hA5, FREE,0, IDLE, 0,0,0,1, 0,0));
        tbl.push_back(mk(0,1,1, 0,'h310,'hA5, ACCESS,0, DGRANT, 0,1,0,0, 'h310,'hA5));
        tbl.push_back(mk(0,0,0, 0,0,0, FREE,0, IDLE, 0,0,0,0, 0,0));
        // request dropped mid-grant
        tbl.push_back(mk(1,0,0, 'h108,0,0, FREE,0, IDLE, 0,0,1,0, 0,0));
        tbl.push_back(mk(0,0,0, 'h108,0,0, BUSY,0, IGRANT, 0,0,1,0, 'h108,0));
        tbl.push_back(mk(0,0,0, 0,0,0, FREE,0, IDLE, 0,0,0,0, 0,0));

        foreach (tbl[k]) begin
            drive(tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].ia, tbl[k].da, tbl[k].ds, tbl[k].rs, tbl[k].ld);
            #1;
            chk($sformatf("v%0d.state", k), 32'(dut.state), 32'(tbl[k].st));
            chk($sformatf("v%0d.ramREN", k), ramREN, tbl[k].ren);
            chk($sformatf("v%0d.ramWEN", k), ramWEN, tbl[k].wen);
            chk($sformatf("v%0d.iwait", k), iwait, tbl[k].iw);
            chk($sformatf("v%0d.dwait", k), dwait, tbl[k].dwt);
            chk($sformatf("v%0d.iload", k), iload, tbl[k].ld);
            chk($sformatf("v%0d.dload", k), dload, tbl[k].ld);
            if (tbl[k].st != IDLE) begin
                chk($sformatf("v%0d.ramaddr", k), ramaddr, tbl[k].addr);
                chk($sformatf("v%0d.ramstore", k), ramstore, tbl[k].store);
            end
            @(negedge CLK);
        end

        // starvation: icache held against continuous dcache reads
        nd = 0;
        igot = 1'b0;
        for (int c = 0; c < 40 && !igot; c++) begin
            drive(1, 1, 0, 'h400, 'h500, 0, ACCESS, c);
            #1;
            if (ramREN && !dwait && ramaddr == 'h500) nd++;
            if (ramREN && !iwait && ramaddr == 'h400) begin
                igot = 1'b1;
                chk("starve.streak_at_grant", 32'(dut.streak), LIMIT);
                chk("starve.dwait_at_igrant", dwait, 1'b1);
            end
            @(negedge CLK);
        end
        chk("starve.icache_granted", igot, 1'b1);
        chk("starve.dcache_completions", nd, LIMIT);
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        #1;
        chk("starve.streak_cleared", 32'(dut.streak), 0);
        chk("starve.idle", 32'(dut.state), 32'(IDLE));
        @(negedge CLK);

        // reset while the icache grant is waiting on BUSY
        drive(1, 1, 0, 'h600, 'h700, 0, FREE, 0);
        @(negedge CLK);
        drive(1, 1, 0, 'h600, 'h700, 0, ACCESS, 0);
        @(negedge CLK);
        drive(1, 0, 0, 'h600, 0, 0, FREE, 0);
        #1;
        chk("abort.streak_before", 32'(dut.streak), 1);
        @(negedge CLK);
        drive(1, 0, 0, 'h600, 0, 0, BUSY, 0);
        #1;
        chk("abort.igrant", 32'(dut.state), 32'(IGRANT));
        chk("abort.ren_busy", ramREN, 1'b1);
        nRST = 1'b0;
        @(negedge CLK);
        #1;
        chk("abort.state", 32'(dut.state), 32'(IDLE));
        chk("abort.ramREN", ramREN, 1'b0);
        chk("abort.iwait", iwait, 1'b1);
        chk("abort.streak", 32'(dut.streak), 0);
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        @(negedge CLK);

        // randomized traffic against the model
        m_owner = 0;
        m_streak = 0;
        for (int c = 0; c < 3000; c++) begin
            nRST = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 99) < 15) iREN = ~iREN;
            if ($urandom_range(0, 99) < 15) dREN = ~dREN;
            if ($urandom_range(0, 99) < 10) dWEN = ~dWEN;
            iaddr = $urandom;
            daddr = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            ramstate = ramstate_t'($urandom_range(0, 3));
            #1;
            dq = dREN | dWEN;
            acc = (ramstate == ACCESS);
            e_addr = 0;
            e_store = 0;
            case (m_owner)
                1: begin e_ren = iREN; e_wen = 0; e_iw = !acc; e_dw = dq; e_addr = iaddr; end
                2: begin e_ren = dREN && !dWEN; e_wen = dWEN; e_iw = iREN; e_dw = !acc;
                         e_addr = daddr; e_store = dstore; end
                default: begin e_ren = 0; e_wen = 0; e_iw = iREN; e_dw = dq; end
            endcase
            chk("rnd.ramREN", ramREN, e_ren);
            chk("rnd.ramWEN", ramWEN, e_wen);
            chk("rnd.iwait", iwait, e_iw);
            chk("rnd.dwait", dwait, e_dw);
            chk("rnd.iload", iload, ramload);
            chk("rnd.dload", dload, ramload);
            chk("rnd.streak", 32'(dut.streak), m_streak);
            if (m_owner != 0) begin
                chk("rnd.ramaddr", ramaddr, e_addr);
                chk("rnd.ramstore", ramstore, e_store);
            end
            if (!nRST) begin
                m_owner = 0;
                m_streak = 0;
            end else if (m_owner == 0) begin
                if (dq) m_owner = (iREN && m_streak == LIMIT) ? 1 : 2;
                else if (iREN) m_owner = 1;
            end else if (m_owner == 1) begin
                if (!iREN) m_owner = 0;
                else if (acc) begin m_owner = 0; m_streak = 0; end
            end else begin
                if (!dq) m_owner = 0;
                else if (acc) begin
                    m_owner = 0;
                    m_streak = iREN ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
                end
            end
            @(negedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter list SHALL be exactly: STARVE_LIMIT, default 4, the number of consecutive dcache completions allowed while an icache request waits.
REQ-002 The ports SHALL be, one per line:
- CLK  in  1  system clock; all state changes on the rising edge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-003 The block SHALL implement the FSM states IDLE, IGRANT and DGRANT.
REQ-004 In IDLE, ramREN and ramWEN SHALL be 0, and iwait/dwait SHALL equal iREN/(dREN|dWEN) respectively.
REQ-005 In IDLE with dREN|dWEN high, the next state SHALL be DGRANT unless iREN is high and streak==STARVE_LIMIT, in which case it SHALL be IGRANT.
REQ-006 In IDLE with only iREN high, the next state SHALL be IGRANT; with no request the FSM SHALL stay in IDLE.
REQ-007 In IGRANT, the outputs SHALL be ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-008 In DGRANT, the outputs SHALL be ramREN=dREN&~dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; a write SHALL take priority over a read.
REQ-009 In a grant state, the granted requester's wait SHALL be 0 only in a cycle where ramstate==ACCESS (combinational), and the non-granted requester's wait SHALL equal its request.
REQ-010 iload and dload SHALL equal ramload at all times; data is valid only when the matching wait is 0.
REQ-011 On ramstate==ACCESS in a grant state, the next state SHALL be IDLE (one dead cycle between transactions).
REQ-012 On ramstate BUSY, FREE or ERROR, the FSM SHALL hold the grant and keep driving the RAM lines; ERROR SHALL be retried implicitly with no extra signalling.
REQ-013 If the granted request drops before ACCESS, the FSM SHALL return to IDLE next cycle with the RAM enables following the dropped request (0).
REQ-014 streak (width clog2(STARVE_LIMIT+1)) SHALL increment on DGRANT completion when iREN==1, saturating at STARVE_LIMIT.
REQ-015 streak SHALL clear on IGRANT completion and on DGRANT completion with iREN==0.
REQ-016 Simultaneous iREN and dREN|dWEN in IDLE SHALL follow REQ-005 only; no other tie-break SHALL exist.

Reset
REQ-017 On a CLK edge with nRST==0, the state SHALL become IDLE and streak SHALL become 0.
REQ-018 Reset during a grant SHALL abandon the transaction; the next cycle outputs SHALL follow REQ-004.
REQ-019 Output values while nRST is low SHALL follow the registered state in effect (combinational outputs only).

Structure
REQ-020 word_t (32-bit) and ramstate_t SHALL come from cpu_types_pkg; the arbiter state enum arb_state_t SHALL be added to cpu_types_pkg.
REQ-021 There SHALL be a single module with no sub-module; the state register and streak counter SHALL sit in one always_ff block and the decode in one always_comb block.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then idle: nRST=0 for 2 cycles, then all requests 0 -> ramREN=ramWEN=0, iwait=dwait=0, state IDLE.
- Single fetch: iREN=1, iaddr=0x100, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramaddr=0x100; iwait=0 for exactly 1 cycle with iload=0xDEADBEEF; then IDLE.
- Contention: iREN=1 and dWEN=1 (daddr=0x200, dstore=0x55) in the same cycle -> DGRANT first with ramWEN=1, ramstore=0x55 and iwait=1; IGRANT after the dead cycle.
- Starvation, STARVE_LIMIT=4: iREN held with continuous dREN -> exactly 4 dcache completions, then the icache is granted; streak back to 0.
- ERROR retry: DGRANT read gets ERROR, ERROR, ACCESS -> ramREN held 3 cycles; dwait=0 only on the ACCESS cycle.
- Mid-grant abort: nRST=0 while ramstate=BUSY in IGRANT -> IDLE next cycle, ramREN=0, streak=0.
